muldiv_hilo: RTL and testbench
==============================

# muldiv_hilo

Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair, replacing the divider and separate HI/LO register inside the execute stage of the five-stage MIPS core. It accepts one operation per start from the E stage. It raises a stall for the pipeline-control unit while iterating and commits HI/LO atomically on completion. A pending operation is aborted without side effects when the M stage takes an exception.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- MUL_ITER, 0: 0 = single-cycle multiply; 1 = iterative shift-add multiply taking WIDTH busy cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-low (rst==0 resets on the next rising clk edge).
- start  in  1  request an operation; sampled only in IDLE.
- op  in  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- a  in  WIDTH  rs operand, sampled with start.
- b  in  WIDTH  rt operand, sampled with start.
- hi_we  in  1  MTHI write.
- lo_we  in  1  MTLO write.
- wdata  in  WIDTH  MTHI/MTLO data.
- cancel  in  1  M-stage exception; aborts any pending or requested operation.
- stall  out  1  hold the E stage; combinational.
- done  out  1  one-cycle pulse, HI/LO just committed.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- FSM states are IDLE and BUSY. A down-counter of ceil(log2(WIDTH+1)) bits tracks iterations.
- IDLE with start & ~cancel:
  - Latch the operands and op, then go to BUSY with count = WIDTH-1.
  - Exception: MULT/MULTU with MUL_ITER=0 stays in IDLE and writes {HI,LO} = product at the same edge.
- BUSY: one radix-2 step per cycle. At count==0, commit {HI,LO} at the edge and return to IDLE.
- Multiply: {HI,LO} = a*b, a 2·WIDTH-bit product. MULT is signed; MULTU is unsigned.
- Divide:
  - LO = quotient, HI = remainder, truncated toward zero.
  - The remainder takes the sign of the dividend.
  - Signed operations use magnitudes, with the signs fixed at commit.
- Divide by zero: LO = all ones, HI = a. This applies to both DIV and DIVU, independent of sign.
- Signed overflow (most-negative / -1): LO = most-negative value, HI = 0.
- hi_we/lo_we: write wdata in IDLE when no start is present. In BUSY they are ignored; the pipeline is stalled, so this does not occur legally.
- start with hi_we or lo_we in the same cycle: start wins and the write is dropped.
- cancel in any cycle:
  - Return to IDLE at the next edge. HI/LO are unchanged and done stays low.
  - cancel with start in the same cycle: no operation is launched.
- Reset: state = IDLE, count = 0, hi = 0, lo = 0, done = 0. An operation in progress when reset occurs is discarded.

## Timing
- stall = (IDLE & start & ~cancel & iterative-op) | (BUSY & ~cancel).
- Iterative operation started in cycle C0:
  - stall is high for C0..C_WIDTH.
  - hi/lo hold the new value and done=1 in cycle C_WIDTH+1.
  - Total latency is WIDTH+1 cycles, so DIV at WIDTH=32 takes 33 cycles.
- Single-cycle multiply (MUL_ITER=0): stall is never asserted; hi/lo are new and done=1 in C1.
- MTHI/MTLO: the new value is visible on hi/lo in the next cycle; done is not pulsed.
- Back-to-back: a new start is accepted in the same cycle done is high.
- Outputs hi, lo and done are registered; stall is combinational from start, op, cancel and state.

## Structure
- Package muldiv_pkg holds:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - state enum MD_IDLE, MD_BUSY;
  - a function returning the counter width from WIDTH.
- One sub-module, div_iter: the restoring radix-2 divider core (magnitude inputs, step/load controls, quotient/remainder outputs).
- The sign fix-up, multiplier, HI/LO registers and FSM live in muldiv_hilo.

## Test plan
All scenarios use WIDTH=32.
- Reset with rst=0 for 2 cycles → hi=0, lo=0, stall=0, done=0.
- DIV, a=7, b=0xFFFFFFFE (-2) → stall for 33 cycles; then lo=0xFFFFFFFD, hi=0x00000001, one done pulse.
- DIVU, a=100, b=7 → lo=14, hi=2.
- DIVU, a=5, b=0 → lo=0xFFFFFFFF, hi=5.
- MULT, a=0xFFFFFFFF, b=2:
  - MUL_ITER=0 → hi=0xFFFFFFFF, lo=0xFFFFFFFE in the next cycle, stall never high.
  - MUL_ITER=1 → same result after 33 cycles.
- Cancel mid-operation: MTLO 0x1234, then DIV started, then cancel in its 10th busy cycle → IDLE next cycle, lo=0x1234, no done.
- cancel with start in the same cycle → no operation launched.
- Reset (rst=0) asserted mid-DIV → hi=lo=0 and IDLE after the edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the HI/LO multiply/divide unit.
//   - md_op_e     : operation encodings carried on the 2-bit op input
//   - md_state_e  : FSM state encoding (IDLE / BUSY)
//   - md_cnt_width: iteration down-counter width for a given operand width
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Counter must hold WIDTH-1 and count down to zero.
  function automatic int md_cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_iter.sv
// div_iter: restoring radix-2 divider core working on unsigned magnitudes.
// One quotient bit is produced per step, MSB first.
//   clk, rst        : clock, synchronous active-low reset
//   load_i          : capture dividend/divisor and clear the partial remainder
//   step_i          : perform one restoring step
//   dividend_i      : dividend magnitude
//   divisor_i       : divisor magnitude
//   quo_next_o      : quotient after the step about to be taken
//   rem_next_o      : remainder after the step about to be taken
// The "next" outputs let the owner commit on the same edge as the final step.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quo_next_o,
  output logic [WIDTH-1:0] rem_next_o
);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Shift the next dividend bit into the partial remainder and try a
  // subtraction; a set top bit of the trial means the subtraction went
  // negative and the old remainder is kept (restored).
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = shifted[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign quo_next_o = quo_d;
  assign rem_next_o = rem_d;

endmodule

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: multi-cycle multiply/divide unit owning the HI/LO pair.
//   clk, rst   : clock, synchronous active-low reset
//   start, op  : launch MULT/MULTU/DIV/DIVU (sampled only in IDLE)
//   a, b       : rs / rt operands, sampled with start
//   hi_we/lo_we, wdata : MTHI / MTLO writes (IDLE, no start)
//   cancel     : M-stage exception, aborts pending or requested operation
//   stall      : combinational hold request for the E stage
//   done       : one-cycle pulse after HI/LO commit
//   hi, lo     : registered HI/LO
// Handshake: an operation is accepted when start=1 and cancel=0 in IDLE;
// its result is committed and done pulses exactly once per accepted
// operation unless cancel or reset intervenes first.
// Signed operations run on magnitudes; signs are applied at commit.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_ITER = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             cancel,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int             CW       = md_cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  md_state_e        state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;
  logic             div_q;       // latched op is a divide
  logic             neg_quo_q;   // negate product / quotient at commit
  logic             neg_rem_q;   // negate remainder at commit
  logic             b_zero_q;    // divide by zero
  logic [WIDTH-1:0] a_q;         // raw dividend, returned in HI on /0
  logic [WIDTH-1:0] mcand_q;     // multiplicand magnitude
  logic [2*WIDTH-1:0] mul_acc_q; // {partial product, remaining multiplier}

  // Input decode
  logic             op_signed, op_div, iter_op, accept;
  logic             neg_a_in, neg_b_in;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;
  logic [2*WIDTH-1:0] prod_1c, prod_1c_fix;

  assign op_signed = (op == MD_MULT) || (op == MD_DIV);
  assign op_div    = (op == MD_DIV)  || (op == MD_DIVU);
  assign iter_op   = op_div || (MUL_ITER != 0);
  assign neg_a_in  = op_signed & a[WIDTH-1];
  assign neg_b_in  = op_signed & b[WIDTH-1];
  // The most-negative value maps onto itself, which read as unsigned is
  // exactly its magnitude.
  assign mag_a_in  = neg_a_in ? -a : a;
  assign mag_b_in  = neg_b_in ? -b : b;
  assign accept    = (state_q == MD_IDLE) & start & ~cancel;

  assign stall = ((state_q == MD_IDLE) & start & ~cancel & iter_op) |
                 ((state_q == MD_BUSY) & ~cancel);

  // Single-cycle multiply path
  assign prod_1c     = {{WIDTH{1'b0}}, mag_a_in} * {{WIDTH{1'b0}}, mag_b_in};
  assign prod_1c_fix = (neg_a_in ^ neg_b_in) ? -prod_1c : prod_1c;

  // Iterative shift-add multiply step: add the multiplicand into the upper
  // half when the current multiplier LSB is set, then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc_d;
  assign mul_sum   = {1'b0, mul_acc_q[2*WIDTH-1:WIDTH]} +
                     (mul_acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_acc_d = {mul_sum, mul_acc_q[WIDTH-1:1]};

  // Divider core
  logic             busy_step;
  logic [WIDTH-1:0] div_quo_d, div_rem_d;
  assign busy_step = (state_q == MD_BUSY) & ~cancel;

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept & op_div),
    .step_i     (busy_step & div_q),
    .dividend_i (mag_a_in),
    .divisor_i  (mag_b_in),
    .quo_next_o (div_quo_d),
    .rem_next_o (div_rem_d)
  );

  // Result presented at the final BUSY edge, with sign fix-up.
  logic [WIDTH-1:0] hi_res_d, lo_res_d;
  always_comb begin
    hi_res_d = '0;
    lo_res_d = '0;
    if (div_q) begin
      if (b_zero_q) begin
        hi_res_d = a_q;
        lo_res_d = '1;
      end else begin
        lo_res_d = neg_quo_q ? -div_quo_d : div_quo_d;
        hi_res_d = neg_rem_q ? -div_rem_d : div_rem_d;
      end
    end else begin
      {hi_res_d, lo_res_d} = neg_quo_q ? -mul_acc_d : mul_acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      div_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      a_q       <= '0;
      mcand_q   <= '0;
      mul_acc_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (cancel) begin
            // Requested operation and any MTHI/MTLO are dropped.
          end else if (start) begin
            div_q     <= op_div;
            neg_quo_q <= neg_a_in ^ neg_b_in;
            neg_rem_q <= neg_a_in;
            b_zero_q  <= (b == '0);
            a_q       <= a;
            mcand_q   <= mag_a_in;
            mul_acc_q <= {{WIDTH{1'b0}}, mag_b_in};
            if (iter_op) begin
              state_q <= MD_BUSY;
              cnt_q   <= CNT_LAST;
            end else begin
              {hi_q, lo_q} <= prod_1c_fix;
              done_q       <= 1'b1;
            end
          end else begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        MD_BUSY: begin
          if (cancel) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
          end else begin
            mul_acc_q <= mul_acc_d;
            if (cnt_q == '0) begin
              hi_q    <= hi_res_d;
              lo_q    <= lo_res_d;
              done_q  <= 1'b1;
              state_q <= MD_IDLE;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
module tb_muldiv_hilo;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, hi_we, lo_we, cancel;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        stall0, done0, stall1, done1;
  logic [31:0] hi0, lo0, hi1, lo1;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  logic [63:0] mon_e;

  // Clock / reset block
  always #5 clk = ~clk;

  muldiv_hilo #(.WIDTH(32), .MUL_ITER(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .cancel(cancel),
    .stall(stall0), .done(done0), .hi(hi0), .lo(lo0)
  );

  muldiv_hilo #(.WIDTH(32), .MUL_ITER(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .cancel(cancel),
    .stall(stall1), .done(done1), .hi(hi1), .lo(lo1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard: pop expected {HI,LO} whenever done pulses.
  always @(negedge clk) begin
    if (done0 === 1'b1) begin
      done_cnt0++;
      if (exp_q0.size() == 0) begin
        check("u0_unexpected_done", {hi0, lo0}, 64'hx);
      end else begin
        mon_e = exp_q0.pop_front();
        check("u0_result", {hi0, lo0}, mon_e);
      end
    end
    if (done1 === 1'b1) begin
      done_cnt1++;
      if (exp_q1.size() == 0) begin
        check("u1_unexpected_done", {hi1, lo1}, 64'hx);
      end else begin
        mon_e = exp_q1.pop_front();
        check("u1_result", {hi1, lo1}, mon_e);
      end
    end
  end

  // Driver: issue one operation, push expectation, count stall cycles.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [63:0] exp, input logic wr);
    int s0, s1, d0, d1, es0;
    d0 = done_cnt0;
    d1 = done_cnt1;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    lo_we = wr; wdata = 32'hDEAD_BEEF;
    exp_q0.push_back(exp);
    exp_q1.push_back(exp);
    #1;
    s0 = int'(stall0);
    s1 = int'(stall1);
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      s0 += int'(stall0);
      s1 += int'(stall1);
      @(negedge clk);
    end
    es0 = (o[1] == 1'b1) ? 33 : 0;
    check({name, "_u0_stall_cycles"}, 64'(s0), 64'(es0));
    check({name, "_u1_stall_cycles"}, 64'(s1), 64'd33);
    check({name, "_u0_done_pulses"}, 64'(done_cnt0 - d0), 64'd1);
    check({name, "_u1_done_pulses"}, 64'(done_cnt1 - d1), 64'd1);
    check({name, "_u0_queue_drained"}, 64'(exp_q0.size()), 64'd0);
    check({name, "_u1_queue_drained"}, 64'(exp_q1.size()), 64'd0);
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int d0, d1;
    rst = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; cancel = 1'b0;

    // Reset
    repeat (2) @(negedge clk);
    #1;
    check("reset_u0_hilo", {hi0, lo0}, 64'd0);
    check("reset_u1_hilo", {hi1, lo1}, 64'd0);
    check("reset_u0_stall_done", {62'd0, stall0, done0}, 64'd0);
    check("reset_u1_stall_done", {62'd0, stall1, done1}, 64'd0);
    rst = 1'b1;

    // Directed operations
    run_op("div_7_m2",    MD_DIV,   32'd7,          32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 1'b0);
    run_op("divu_100_7",  MD_DIVU,  32'd100,        32'd7,         64'h00000002_0000000E, 1'b1);
    run_op("divu_5_0",    MD_DIVU,  32'd5,          32'd0,         64'h00000005_FFFFFFFF, 1'b0);
    run_op("div_m7_0",    MD_DIV,   32'hFFFF_FFF9,  32'd0,         64'hFFFFFFF9_FFFFFFFF, 1'b0);
    run_op("mult_m1_2",   MD_MULT,  32'hFFFF_FFFF,  32'd2,         64'hFFFFFFFF_FFFFFFFE, 1'b0);
    run_op("div_ovf",     MD_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 64'h00000000_80000000, 1'b0);
    run_op("div_m7_2",    MD_DIV,   32'hFFFF_FFF9,  32'd2,         64'hFFFFFFFF_FFFFFFFD, 1'b0);
    run_op("multu_max",   MD_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'hFFFFFFFE_00000001, 1'b0);
    run_op("mult_m3_5",   MD_MULT,  32'hFFFF_FFFD,  32'd5,         64'hFFFFFFFF_FFFFFFF1, 1'b0);

    // MTHI then MTLO
    @(negedge clk); hi_we = 1'b1; wdata = 32'hAAAA_5555;
    @(negedge clk); hi_we = 1'b0; #1;
    check("mthi_u0", {hi0, lo0}, 64'hAAAA5555_FFFFFFF1);
    check("mthi_u1", {hi1, lo1}, 64'hAAAA5555_FFFFFFF1);
    @(negedge clk); lo_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk); lo_we = 1'b0; #1;
    check("mtlo_u0", {hi0, lo0}, 64'hAAAA5555_00001234);
    check("mtlo_u1", {hi1, lo1}, 64'hAAAA5555_00001234);

    // Cancel in the 10th busy cycle
    d0 = done_cnt0; d1 = done_cnt1;
    @(negedge clk); start = 1'b1; op = MD_DIV; a = 32'd1000; b = 32'd3;
    @(negedge clk); start = 1'b0;
    idle_cycles(9);
    cancel = 1'b1; #1;
    check("cancel_cycle_stall", {62'd0, stall0, stall1}, 64'd0);
    @(negedge clk); cancel = 1'b0; #1;
    check("after_cancel_stall", {62'd0, stall0, stall1}, 64'd0);
    check("after_cancel_u0_hilo", {hi0, lo0}, 64'hAAAA5555_00001234);
    check("after_cancel_u1_hilo", {hi1, lo1}, 64'hAAAA5555_00001234);
    idle_cycles(40);
    check("cancel_no_done", 64'((done_cnt0 - d0) + (done_cnt1 - d1)), 64'd0);

    // cancel together with start
    d0 = done_cnt0; d1 = done_cnt1;
    @(negedge clk); start = 1'b1; cancel = 1'b1; op = MD_DIVU; a = 32'd9; b = 32'd2; #1;
    check("cancel_start_stall", {62'd0, stall0, stall1}, 64'd0);
    @(negedge clk); start = 1'b0; cancel = 1'b0; #1;
    check("cancel_start_not_busy", {62'd0, stall0, stall1}, 64'd0);
    idle_cycles(40);
    check("cancel_start_no_done", 64'((done_cnt0 - d0) + (done_cnt1 - d1)), 64'd0);
    check("cancel_start_u0_hilo", {hi0, lo0}, 64'hAAAA5555_00001234);

    // Reset in the middle of a DIV
    d0 = done_cnt0; d1 = done_cnt1;
    @(negedge clk); start = 1'b1; op = MD_DIV; a = 32'd100; b = 32'd7;
    @(negedge clk); start = 1'b0;
    idle_cycles(5);
    rst = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    check("midreset_u0_hilo", {hi0, lo0}, 64'd0);
    check("midreset_u1_hilo", {hi1, lo1}, 64'd0);
    check("midreset_stall", {62'd0, stall0, stall1}, 64'd0);
    idle_cycles(40);
    check("midreset_no_done", 64'((done_cnt0 - d0) + (done_cnt1 - d1)), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
